// File: rtl/vpu_src_fetch_sched.sv
// Source-operand fetch scheduler: decodes up to SRC_OPERAND_CNT operand addresses, issues banked
// SRAM reads (serialising bank conflicts, merging identical rows) and presents the gathered bundle.
module vpu_src_fetch_sched #(
    parameter int SRAM_BANK_CNT      = 4,
    parameter int SRAM_BANK_DEPTH    = 1024,
    parameter int SRAM_DATA_WIDTH    = 512,
    parameter int SRC_OPERAND_CNT    = 3,
    parameter int OPERAND_ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH        = 136,
    parameter int SRAM_RD_LATENCY    = 1,
    localparam int BANK_LG2 = $clog2(SRAM_BANK_CNT),
    localparam int ROW_LG2  = $clog2(SRAM_BANK_DEPTH),
    localparam int DW_LG2   = $clog2(SRAM_DATA_WIDTH),
    localparam int SRC_LG2  = (SRC_OPERAND_CNT > 1) ? $clog2(SRC_OPERAND_CNT) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        instr_valid_i,
    output logic                                        instr_ready_o,
    input  logic [INSTR_WIDTH-1:0]                      instr_i,
    input  logic [SRC_OPERAND_CNT-1:0]                  src_mask_i,
    output logic [SRAM_BANK_CNT-1:0]                    sram_rd_en_o,
    output logic [SRAM_BANK_CNT*ROW_LG2-1:0]            sram_rd_addr_o,
    input  logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0]    sram_rdata_i,
    output logic                                        opnd_valid_o,
    input  logic                                        opnd_ready_i,
    output logic [SRC_OPERAND_CNT*SRAM_DATA_WIDTH-1:0]  opnd_data_o,
    output logic [7:0]                                  opnd_opcode_o,
    output logic [OPERAND_ADDR_WIDTH-1:0]               opnd_dst_o
);

    localparam int DW  = SRAM_DATA_WIDTH;
    localparam int SRC = SRC_OPERAND_CNT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_instr_ready;
    logic [SRC-1:0]                 r_pending;
    logic [OPERAND_ADDR_WIDTH-1:0]  r_src_addr [SRC];
    logic [7:0]                     r_opcode;
    logic [OPERAND_ADDR_WIDTH-1:0]  r_dst;
    logic [SRC*DW-1:0]              r_opnd_data;
    logic [SRC-1:0]                 r_tag_pipe [SRAM_BANK_CNT][SRAM_RD_LATENCY];

    logic                           w_accept;
    logic [BANK_LG2-1:0]            w_bank [SRC];
    logic [ROW_LG2-1:0]             w_row [SRC];
    logic [SRC-1:0]                 w_bank_hit [SRAM_BANK_CNT];
    logic [SRC_LG2-1:0]             w_grant_idx [SRAM_BANK_CNT];
    logic [SRC-1:0]                 w_tag_issue [SRAM_BANK_CNT];
    logic [SRC-1:0]                 w_granted;
    logic                           w_pipe_busy;
    logic                           w_unused_addr;

    assign w_accept = (r_state == ST_IDLE) && instr_valid_i && r_instr_ready;

    // Decode bank and row of each captured source address; only bits [20:9] matter
    always_comb begin
        w_unused_addr = 1'b0;
        for (int i = 0; i < SRC; i++) begin
            w_bank[i]     = r_src_addr[i][DW_LG2 +: BANK_LG2];
            w_row[i]      = r_src_addr[i][BANK_LG2+DW_LG2 +: ROW_LG2];
            w_unused_addr = w_unused_addr ^ (^r_src_addr[i]);
        end
    end

    // Per-bank arbitration: lowest pending src wins, same-row srcs ride along
    always_comb begin
        for (int b = 0; b < SRAM_BANK_CNT; b++) begin
            w_grant_idx[b] = '0;
            for (int i = 0; i < SRC; i++) begin
                w_bank_hit[b][i] = (r_state == ST_ISSUE) && r_pending[i]
                                   && (w_bank[i] == BANK_LG2'(b));
            end
            for (int i = SRC-1; i >= 0; i--) begin
                if (w_bank_hit[b][i]) begin
                    w_grant_idx[b] = SRC_LG2'(i);
                end else begin
                    w_grant_idx[b] = w_grant_idx[b];
                end
            end
            for (int i = 0; i < SRC; i++) begin
                w_tag_issue[b][i] = w_bank_hit[b][i] && (w_row[i] == w_row[w_grant_idx[b]]);
            end
        end
    end

    // Drive SRAM read ports and collect the set of srcs serviced this cycle
    always_comb begin
        sram_rd_en_o   = '0;
        sram_rd_addr_o = '0;
        w_granted      = '0;
        for (int b = 0; b < SRAM_BANK_CNT; b++) begin
            sram_rd_en_o[b] = |w_bank_hit[b];
            sram_rd_addr_o[b*ROW_LG2 +: ROW_LG2] = (|w_bank_hit[b]) ? w_row[w_grant_idx[b]]
                                                                    : '0;
            w_granted = w_granted | w_tag_issue[b];
        end
    end

    // Reads still in flight beyond the stage that returns this cycle
    always_comb begin
        w_pipe_busy = 1'b0;
        for (int b = 0; b < SRAM_BANK_CNT; b++) begin
            for (int k = 0; k < SRAM_RD_LATENCY-1; k++) begin
                w_pipe_busy = w_pipe_busy | (|r_tag_pipe[b][k]);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (src_mask_i == '0) ? ST_OUT : ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if ((r_pending & ~w_granted) == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (opnd_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; ready is registered so it reads 0 in the cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    // Per-bank tag delay pipe matching the SRAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < SRAM_BANK_CNT; b++) begin
                for (int k = 0; k < SRAM_RD_LATENCY; k++) begin
                    r_tag_pipe[b][k] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < SRAM_BANK_CNT; b++) begin
                r_tag_pipe[b][0] <= w_tag_issue[b];
                for (int k = 1; k < SRAM_RD_LATENCY; k++) begin
                    r_tag_pipe[b][k] <= r_tag_pipe[b][k-1];
                end
            end
        end
    end

    // Instruction capture, pending bookkeeping and returned-data gathering
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_opcode    <= '0;
            r_dst       <= '0;
            r_opnd_data <= '0;
            for (int i = 0; i < SRC; i++) begin
                r_src_addr[i] <= '0;
            end
        end else if (w_accept) begin
            r_pending   <= src_mask_i;
            r_opcode    <= instr_i[INSTR_WIDTH-1 -: 8];
            r_dst       <= instr_i[OPERAND_ADDR_WIDTH-1:0];
            r_opnd_data <= '0;
            for (int i = 0; i < SRC; i++) begin
                r_src_addr[i] <= instr_i[OPERAND_ADDR_WIDTH*(i+1) +: OPERAND_ADDR_WIDTH];
            end
        end else begin
            r_pending <= r_pending & ~w_granted;
            for (int b = 0; b < SRAM_BANK_CNT; b++) begin
                for (int i = 0; i < SRC; i++) begin
                    if (r_tag_pipe[b][SRAM_RD_LATENCY-1][i]) begin
                        r_opnd_data[i*DW +: DW] <= sram_rdata_i[b*DW +: DW];
                    end
                end
            end
        end
    end

    assign instr_ready_o = r_instr_ready;
    assign opnd_valid_o  = (r_state == ST_OUT);
    assign opnd_data_o   = r_opnd_data;
    assign opnd_opcode_o = r_opcode;
    assign opnd_dst_o    = r_dst;

endmodule

// File: tb/tb_vpu_src_fetch_sched.sv
// Directed bench for vpu_src_fetch_sched with a 1-cycle-latency banked SRAM model.
module tb_vpu_src_fetch_sched;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [135:0]    instr;
    logic [2:0]      src_mask;
    logic [3:0]      rd_en;
    logic [39:0]     rd_addr;
    logic [2047:0]   rdata = '0;
    logic            opnd_valid;
    logic            opnd_ready;
    logic [1535:0]   opnd_data;
    logic [7:0]      opcode;
    logic [31:0]     dst;

    int total = 0;
    int bad   = 0;

    vpu_src_fetch_sched dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid_i  (instr_valid),
        .instr_ready_o  (instr_ready),
        .instr_i        (instr),
        .src_mask_i     (src_mask),
        .sram_rd_en_o   (rd_en),
        .sram_rd_addr_o (rd_addr),
        .sram_rdata_i   (rdata),
        .opnd_valid_o   (opnd_valid),
        .opnd_ready_i   (opnd_ready),
        .opnd_data_o    (opnd_data),
        .opnd_opcode_o  (opcode),
        .opnd_dst_o     (dst)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input int b, input int row);
        logic [31:0] w;
        w = {8'hB0 + 8'(b), 6'd0, 10'(row), 8'hC3};
        return {16{w}};
    endfunction

    // SRAM model: one read port per bank, data one cycle after rd_en
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rd_en[b]) rdata[b*512 +: 512] <= pat(b, int'(rd_addr[b*10 +: 10]));
        end
    end

    task automatic chk(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] d, input logic [31:0] s0,
                        input logic [31:0] s1, input logic [31:0] s2, input logic [2:0] m);
        instr       = {op, s2, s1, s0, d};
        src_mask    = m;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0; src_mask = '0; opnd_ready = 1'b0;
        step();
        chk("rst_ready", 1536'(instr_ready), 1536'(1'b0));
        chk("rst_rd_en", 1536'(rd_en), 1536'(4'b0000));
        chk("rst_rd_addr", 1536'(rd_addr), 1536'(40'h0));
        chk("rst_valid", 1536'(opnd_valid), 1536'(1'b0));
        chk("rst_data", opnd_data, 1536'(0));
        chk("rst_opcode", 1536'(opcode), 1536'(8'h00));
        chk("rst_dst", 1536'(dst), 1536'(32'h0));
        step();
        rst = 1'b0;
        step();
        chk("idle_ready", 1536'(instr_ready), 1536'(1'b1));

        // 1: three different banks, row 0
        send(8'h11, 32'hD0D0_0001, 32'h0000_0000, 32'h0000_0200, 32'h0000_0400, 3'b111);
        chk("t1_rd_en_T1", 1536'(rd_en), 1536'(4'b0111));
        chk("t1_rd_addr_T1", 1536'(rd_addr), 1536'(40'h0));
        chk("t1_ready_T1", 1536'(instr_ready), 1536'(1'b0));
        chk("t1_valid_T1", 1536'(opnd_valid), 1536'(1'b0));
        step();
        chk("t1_rd_en_T2", 1536'(rd_en), 1536'(4'b0000));
        chk("t1_valid_T2", 1536'(opnd_valid), 1536'(1'b0));
        step();
        chk("t1_valid_T3", 1536'(opnd_valid), 1536'(1'b1));
        chk("t1_data", opnd_data, {pat(2, 0), pat(1, 0), pat(0, 0)});
        chk("t1_opcode", 1536'(opcode), 1536'(8'h11));
        chk("t1_dst", 1536'(dst), 1536'(32'hD0D0_0001));
        opnd_ready = 1'b1;
        step();
        opnd_ready = 1'b0;
        chk("t1_valid_done", 1536'(opnd_valid), 1536'(1'b0));
        chk("t1_ready_back", 1536'(instr_ready), 1536'(1'b1));

        // 2: bank-0 conflict rows 0 and 1; src2 points elsewhere but is masked off
        send(8'h22, 32'h0000_0022, 32'h0000_0000, 32'h0000_0800, 32'h0000_0400, 3'b011);
        chk("t2_rd_en_T1", 1536'(rd_en), 1536'(4'b0001));
        chk("t2_rd_addr_T1", 1536'(rd_addr), 1536'(40'h0));
        step();
        chk("t2_rd_en_T2", 1536'(rd_en), 1536'(4'b0001));
        chk("t2_rd_addr_T2", 1536'(rd_addr), 1536'(40'h1));
        step();
        chk("t2_rd_en_T3", 1536'(rd_en), 1536'(4'b0000));
        chk("t2_valid_T3", 1536'(opnd_valid), 1536'(1'b0));
        step();
        chk("t2_valid_T4", 1536'(opnd_valid), 1536'(1'b1));
        chk("t2_data", opnd_data, {512'h0, pat(0, 1), pat(0, 0)});
        opnd_ready = 1'b1;
        step();
        opnd_ready = 1'b0;

        // 3: all three srcs merge onto bank1 row3 (src2 has high bits set, ignored)
        send(8'h33, 32'h0000_0033, 32'h0000_1A00, 32'h0000_1A00, 32'hFFE0_1A00, 3'b111);
        chk("t3_rd_en_T1", 1536'(rd_en), 1536'(4'b0010));
        chk("t3_rd_addr_T1", 1536'(rd_addr), 1536'(40'hC00));
        step();
        chk("t3_rd_en_T2", 1536'(rd_en), 1536'(4'b0000));
        step();
        chk("t3_valid_T3", 1536'(opnd_valid), 1536'(1'b1));
        chk("t3_data", opnd_data, {pat(1, 3), pat(1, 3), pat(1, 3)});
        opnd_ready = 1'b1;
        step();
        opnd_ready = 1'b0;

        // 4: empty mask, then back-pressure for 5 cycles with a competing instruction
        send(8'hA5, 32'hCAFE_F00D, 32'h0000_0200, 32'h0000_0400, 32'h0000_0600, 3'b000);
        chk("t4_valid_T1", 1536'(opnd_valid), 1536'(1'b1));
        chk("t4_rd_en_T1", 1536'(rd_en), 1536'(4'b0000));
        chk("t4_data", opnd_data, 1536'(0));
        chk("t4_opcode", 1536'(opcode), 1536'(8'hA5));
        chk("t4_dst", 1536'(dst), 1536'(32'hCAFE_F00D));
        instr       = {8'h5A, 32'h0000_0200, 32'h0000_0200, 32'h0000_0200, 32'h1234_5678};
        src_mask    = 3'b111;
        instr_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t4_hold_valid", 1536'(opnd_valid), 1536'(1'b1));
            chk("t4_hold_ready", 1536'(instr_ready), 1536'(1'b0));
            chk("t4_hold_rd_en", 1536'(rd_en), 1536'(4'b0000));
            chk("t4_hold_opcode", 1536'(opcode), 1536'(8'hA5));
            chk("t4_hold_dst", 1536'(dst), 1536'(32'hCAFE_F00D));
        end
        instr_valid = 1'b0;
        opnd_ready  = 1'b1;
        step();
        opnd_ready  = 1'b0;
        chk("t4_release_valid", 1536'(opnd_valid), 1536'(1'b0));
        chk("t4_release_opcode", 1536'(opcode), 1536'(8'hA5));

        // 5: merge plus conflict on bank0, lowest index granted first
        send(8'h55, 32'h0000_0055, 32'h0000_0800, 32'h0000_0000, 32'h0000_0800, 3'b111);
        chk("t5_rd_en_T1", 1536'(rd_en), 1536'(4'b0001));
        chk("t5_rd_addr_T1", 1536'(rd_addr), 1536'(40'h1));
        step();
        chk("t5_rd_addr_T2", 1536'(rd_addr), 1536'(40'h0));
        chk("t5_rd_en_T2", 1536'(rd_en), 1536'(4'b0001));
        step();
        step();
        chk("t5_valid_T4", 1536'(opnd_valid), 1536'(1'b1));
        chk("t5_data", opnd_data, {pat(0, 1), pat(0, 0), pat(0, 1)});
        opnd_ready = 1'b1;
        step();
        opnd_ready = 1'b0;

        // 6: reset pulse in the cycle after the first ISSUE round of a conflict
        send(8'h66, 32'h0000_0066, 32'h0000_0000, 32'h0000_0800, 32'h0000_0000, 3'b011);
        chk("t6_rd_en_T1", 1536'(rd_en), 1536'(4'b0001));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_ready", 1536'(instr_ready), 1536'(1'b0));
        chk("t6_rst_rd_en", 1536'(rd_en), 1536'(4'b0000));
        chk("t6_rst_rd_addr", 1536'(rd_addr), 1536'(40'h0));
        chk("t6_rst_valid", 1536'(opnd_valid), 1536'(1'b0));
        chk("t6_rst_data", opnd_data, 1536'(0));
        chk("t6_rst_opcode", 1536'(opcode), 1536'(8'h00));
        chk("t6_rst_dst", 1536'(dst), 1536'(32'h0));
        step();
        chk("t6_post_rd_en", 1536'(rd_en), 1536'(4'b0000));
        chk("t6_post_data", opnd_data, 1536'(0));
        chk("t6_post_ready", 1536'(instr_ready), 1536'(1'b1));
        send(8'h77, 32'h0000_0077, 32'h0000_0600, 32'h0000_0A00, 32'h0000_1000, 3'b111);
        chk("t6_new_rd_en", 1536'(rd_en), 1536'(4'b1011));
        chk("t6_new_rd_addr", 1536'(rd_addr), 1536'(40'h402));
        step();
        step();
        chk("t6_new_valid", 1536'(opnd_valid), 1536'(1'b1));
        chk("t6_new_data", opnd_data, {pat(0, 2), pat(1, 1), pat(3, 0)});
        chk("t6_new_opcode", 1536'(opcode), 1536'(8'h77));
        opnd_ready = 1'b1;
        step();
        opnd_ready = 1'b0;
        chk("t6_done_valid", 1536'(opnd_valid), 1536'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
